// File: rtl/msg_block_buffer_pkg.sv
// Purpose: shared constants and bank-state type for the Blake2s message block buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package blake2s_pkg;

  // Bytes per Blake2s message block; fixed by the hash definition.
  localparam int BLOCK_BYTES = 64;
  // Width of the running byte-offset counter t.
  localparam int T_W = 64;
  // Width of a byte index inside one block.
  localparam int IDX_W = $clog2(BLOCK_BYTES);
  // Width of one whole block in bits.
  localparam int BLK_W = BLOCK_BYTES * 8;

  // Life cycle of one bank: collecting bytes, waiting for the compressor, free.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    PEND  = 2'd2
  } bank_state_e;

  // Byte count of a final block. 0 encodes a full block; anything beyond a
  // full block is clamped so the close index stays inside the bank.
  function automatic logic [7:0] final_len(input logic [7:0] ll);
    logic [7:0] len;
    if ((ll == 8'd0) || (ll > 8'(BLOCK_BYTES))) begin
      len = 8'(BLOCK_BYTES);
    end else begin
      len = ll;
    end
    return len;
  endfunction

endpackage

// File: rtl/msg_block_buffer_if.sv
// Purpose: byte-in / block-out bundle between the message source, the buffer and the compressor.
// Latency: wires only.
// Backpressure: full_o stops the byte source; blk_ready_i stalls the block output.
interface msg_block_buffer_if;
  import blake2s_pkg::*;

  // Byte stream from the message source.
  logic             data_v_i;
  logic [7:0]       data_i;
  logic [IDX_W-1:0] data_idx_i;
  logic             block_first_i;
  logic             block_last_i;
  logic [7:0]       ll_i;

  // Block stream towards the compression stage.
  logic             blk_v_o;
  logic             blk_ready_i;
  logic [BLK_W-1:0] blk_o;
  logic [T_W-1:0]   blk_t_o;
  logic             blk_first_o;
  logic             blk_last_o;

  // Status back to the source.
  logic             full_o;
  logic             err_o;

  // Source of bytes and sink of blocks (the surrounding system).
  modport master (
    output data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i,
    output blk_ready_i,
    input  blk_v_o, blk_o, blk_t_o, blk_first_o, blk_last_o,
    input  full_o, err_o
  );

  // The buffer itself.
  modport slave (
    input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i,
    input  blk_ready_i,
    output blk_v_o, blk_o, blk_t_o, blk_first_o, blk_last_o,
    output full_o, err_o
  );

endinterface

// File: rtl/msg_block_buffer_bank.sv
// Purpose: one 64-byte message bank with its EMPTY/FILL/PEND state, flags and t value.
// Latency: a write or close is visible in state/data the next cycle.
// Backpressure: none inside; the parent only writes while the bank is EMPTY or FILL.
module msg_bank
  import blake2s_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_byte,
  input  logic             first_in,
  input  logic             close,
  input  logic             last_in,
  input  logic [T_W-1:0]   t_in,
  input  logic             drain,
  output bank_state_e      state,
  output logic [BLK_W-1:0] data,
  output logic             first,
  output logic             last,
  output logic [T_W-1:0]   t
);

  // Bank state machine: fill on writes, seal on close, wipe on drain.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= EMPTY;
      data  <= '0;
      first <= 1'b0;
      last  <= 1'b0;
      t     <= '0;
    end else if (drain) begin
      // Wiping here keeps unwritten tail bytes of the next block at zero.
      state <= EMPTY;
      data  <= '0;
      first <= 1'b0;
      last  <= 1'b0;
      t     <= '0;
    end else if (wr_en) begin
      data[{wr_idx, 3'b000} +: 8] <= wr_byte;
      if (state == EMPTY) begin
        // The first byte into a free bank decides whether it opens a message.
        state <= FILL;
        first <= first_in;
      end
      if (close) begin
        // A closing byte wins over the EMPTY->FILL step (one-byte blocks).
        state <= PEND;
        last  <= last_in;
        t     <= t_in;
      end
    end
  end

endmodule

// File: rtl/msg_block_buffer.sv
// Purpose: ping-pong buffer packing a byte stream into 64-byte Blake2s blocks with running t.
// Latency: block offered the cycle after its closing byte when no older block is waiting.
// Backpressure: blk_ready_i holds the offered block; full_o rises when both banks wait, bytes then dropped and err_o set.
module msg_block_buffer
  import blake2s_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  msg_block_buffer_if.slave  bus
);

  // Per-bank view.
  bank_state_e      st     [2];
  logic [BLK_W-1:0] bdata  [2];
  logic             bfirst [2];
  logic             blast  [2];
  logic [T_W-1:0]   bt     [2];

  // Pointers: fill_ptr is the bank taking bytes, drain_ptr the oldest sealed bank.
  logic             fill_ptr;
  logic             drain_ptr;
  logic [T_W-1:0]   t_run;
  logic             err;

  // Per-cycle decisions.
  logic             full;
  logic             accept;
  logic             fill_empty;
  logic             first_reset;
  logic [7:0]       blk_len;
  logic [IDX_W-1:0] last_idx;
  logic             close;
  logic [T_W-1:0]   t_base;
  logic [T_W-1:0]   t_new;
  logic             hs;

  // Byte acceptance, close detection, t arithmetic and drain handshake.
  always_comb begin
    full        = (st[0] == PEND) && (st[1] == PEND);
    accept      = bus.data_v_i && !full;
    fill_empty  = (st[fill_ptr] == EMPTY);
    // A message start restarts t before this block's own byte count is added.
    first_reset = accept && fill_empty && bus.block_first_i;
    blk_len     = bus.block_last_i ? final_len(bus.ll_i) : 8'(BLOCK_BYTES);
    last_idx    = IDX_W'(blk_len - 8'd1);
    close       = accept && (bus.data_idx_i == last_idx);
    t_base      = first_reset ? '0 : t_run;
    t_new       = t_base + T_W'(blk_len);
    hs          = (st[drain_ptr] == PEND) && bus.blk_ready_i;
  end

  // Pointer advance, running t and sticky overflow flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      t_run     <= '0;
      err       <= 1'b0;
    end else begin
      if (close) begin
        fill_ptr <= ~fill_ptr;
      end
      if (hs) begin
        drain_ptr <= ~drain_ptr;
      end
      if (close) begin
        // The end of a message returns t to zero for whatever comes next.
        t_run <= bus.block_last_i ? '0 : t_new;
      end else if (first_reset) begin
        t_run <= '0;
      end
      if (bus.data_v_i && full) begin
        err <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);

    msg_bank u_bank (
      .clk      (clk),
      .nreset   (nreset),
      .wr_en    (accept && (fill_ptr == SEL)),
      .wr_idx   (bus.data_idx_i),
      .wr_byte  (bus.data_i),
      .first_in (bus.block_first_i),
      .close    (close && (fill_ptr == SEL)),
      .last_in  (bus.block_last_i),
      .t_in     (t_new),
      .drain    (hs && (drain_ptr == SEL)),
      .state    (st[b]),
      .data     (bdata[b]),
      .first    (bfirst[b]),
      .last     (blast[b]),
      .t        (bt[b])
    );
  end

  // The oldest bank drives the block port; it only changes after a handshake.
  assign bus.blk_v_o     = (st[drain_ptr] == PEND);
  assign bus.blk_o       = bdata[drain_ptr];
  assign bus.blk_t_o     = bt[drain_ptr];
  assign bus.blk_first_o = bfirst[drain_ptr];
  assign bus.blk_last_o  = blast[drain_ptr];
  assign bus.full_o      = full;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_msg_block_buffer.sv
// Purpose: randomized and directed bench for msg_block_buffer against a queue-based block model.
// Latency: checks every negedge against the model state after the preceding posedge.
// Backpressure: random blk_ready_i; the source waits on full_o except where overflow is exercised.
module tb_msg_block_buffer;
  import blake2s_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  msg_block_buffer_if bus ();

  msg_block_buffer dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    logic [BLK_W-1:0] data;
    logic [T_W-1:0]   t;
    logic             first;
    logic             last;
  } blk_s;

  // Model: closed blocks waiting for the compressor, plus the block being assembled.
  blk_s        pend [$];
  byte unsigned cur [BLOCK_BYTES];
  bit          open_blk;
  bit          cur_first;
  logic [63:0] m_t;
  bit          m_err;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: a byte list becomes a block when its last position arrives.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend.delete();
      open_blk = 1'b0;
      m_t      = '0;
      m_err    = 1'b0;
    end else begin
      int   len;
      bit   full_now;
      blk_s nb;
      full_now = (pend.size() == 2);
      if (bus.data_v_i && full_now) m_err = 1'b1;
      if ((pend.size() > 0) && bus.blk_ready_i) void'(pend.pop_front());
      if (bus.data_v_i && !full_now) begin
        if (!open_blk) begin
          open_blk  = 1'b1;
          cur_first = bus.block_first_i;
          foreach (cur[i]) cur[i] = 8'h00;
          if (bus.block_first_i) m_t = '0;
        end
        cur[bus.data_idx_i] = bus.data_i;
        if (!bus.block_last_i) len = 64;
        else if (bus.ll_i == 8'd0) len = 64;
        else len = int'(bus.ll_i);
        if (int'(bus.data_idx_i) == len - 1) begin
          m_t = m_t + 64'(len);
          for (int i = 0; i < BLOCK_BYTES; i++) nb.data[8*i +: 8] = cur[i];
          nb.t     = m_t;
          nb.first = cur_first;
          nb.last  = bus.block_last_i;
          pend.push_back(nb);
          open_blk = 1'b0;
          if (bus.block_last_i) m_t = '0;
        end
      end
    end
  end

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("blk_v", bus.blk_v_o, pend.size() > 0);
      check("full", bus.full_o, pend.size() == 2);
      check("err", bus.err_o, m_err);
      if (pend.size() > 0) begin
        check("blk_data", bus.blk_o, pend[0].data);
        check("blk_t", bus.blk_t_o, pend[0].t);
        check("blk_first", bus.blk_first_o, pend[0].first);
        check("blk_last", bus.blk_last_o, pend[0].last);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int idx, input bit f, input bit l, input logic [7:0] ll);
    bus.data_v_i      = 1'b1;
    bus.data_i        = d;
    bus.data_idx_i    = IDX_W'(idx);
    bus.block_first_i = f;
    bus.block_last_i  = l;
    bus.ll_i          = ll;
    cycle();
    bus.data_v_i      = 1'b0;
  endtask

  task automatic send_block(input bit f, input bit l, input logic [7:0] ll, input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) send(seed + 8'(i), i, f, l, ll);
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_blk_v"}, bus.blk_v_o, 0);
    check({tag, "_blk_o"}, bus.blk_o, 0);
    check({tag, "_blk_t"}, bus.blk_t_o, 0);
    check({tag, "_first"}, bus.blk_first_o, 0);
    check({tag, "_last"}, bus.blk_last_o, 0);
    check({tag, "_full"}, bus.full_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLK_W-1:0] exp;
    nreset            = 1'b0;
    bus.data_v_i      = 1'b0;
    bus.data_i        = '0;
    bus.data_idx_i    = '0;
    bus.block_first_i = 1'b0;
    bus.block_last_i  = 1'b0;
    bus.ll_i          = '0;
    bus.blk_ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    zero_checks("reset");
    #2 nreset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Single full-length message: byte i = i, t = 64.
    bus.blk_ready_i = 1'b1;
    send_block(1'b1, 1'b1, 8'd0, 64, 8'h00);
    for (int i = 0; i < BLOCK_BYTES; i++) exp[8*i +: 8] = 8'(i);
    check("t1_v", bus.blk_v_o, 1);
    check("t1_data", bus.blk_o, exp);
    check("t1_t", bus.blk_t_o, 64);
    check("t1_first", bus.blk_first_o, 1);
    check("t1_last", bus.blk_last_o, 1);
    cycle();

    // Full block then a 3-byte final block: zero tail, t = 67.
    send_block(1'b1, 1'b0, 8'd0, 64, 8'h40);
    send(8'hA1, 0, 1'b0, 1'b1, 8'd3);
    send(8'hA2, 1, 1'b0, 1'b1, 8'd3);
    send(8'hA3, 2, 1'b0, 1'b1, 8'd3);
    check("t2_v", bus.blk_v_o, 1);
    check("t2_data", bus.blk_o, 512'hA3A2A1);
    check("t2_t", bus.blk_t_o, 67);
    check("t2_first", bus.blk_first_o, 0);
    check("t2_last", bus.blk_last_o, 1);
    cycle();

    // Handshake on the same cycle as the next closing byte: no bubble.
    bus.blk_ready_i = 1'b0;
    send_block(1'b1, 1'b0, 8'd0, 64, 8'h00);
    send_block(1'b0, 1'b0, 8'd0, 63, 8'h80);
    bus.blk_ready_i = 1'b1;
    send(8'hFF, 63, 1'b0, 1'b0, 8'd0);
    check("t4_v", bus.blk_v_o, 1);
    check("t4_t", bus.blk_t_o, 128);
    check("t4_first", bus.blk_first_o, 0);
    cycle();
    check("t4_drained", bus.blk_v_o, 0);

    // Two blocks held back: full, overflow byte dropped, in-order drain.
    bus.blk_ready_i = 1'b0;
    send_block(1'b1, 1'b1, 8'd0, 64, 8'h11);
    send_block(1'b1, 1'b1, 8'd0, 64, 8'h22);
    check("t3_full", bus.full_o, 1);
    send(8'h99, 0, 1'b1, 1'b1, 8'd0);
    check("t3_err", bus.err_o, 1);
    bus.blk_ready_i = 1'b1;
    check("t3_first_out", bus.blk_o[7:0], 8'h11);
    cycle();
    check("t3_second_out", bus.blk_o[7:0], 8'h22);
    check("t3_second_v", bus.blk_v_o, 1);
    check("t3_not_full", bus.full_o, 0);
    cycle();
    check("t3_empty", bus.blk_v_o, 0);
    check("t3_err_sticky", bus.err_o, 1);

    // Reset in the middle of a block discards it and clears the error.
    send_block(1'b1, 1'b0, 8'd0, 20, 8'h30);
    #2 nreset = 1'b0;
    #1 zero_checks("midrst");
    @(negedge clk);
    #2 nreset = 1'b1;
    @(negedge clk);
    send_block(1'b1, 1'b1, 8'd0, 64, 8'h05);
    check("t5_v", bus.blk_v_o, 1);
    check("t5_t", bus.blk_t_o, 64);
    cycle();

    // Random messages with random gaps and random compressor stalls.
    for (int m = 0; m < 25; m++) begin
      int nblk;
      nblk = $urandom_range(1, 3);
      for (int b = 0; b < nblk; b++) begin
        bit         lst;
        int         n;
        logic [7:0] ll;
        lst = (b == nblk - 1);
        n   = lst ? $urandom_range(1, 64) : 64;
        if (lst) ll = ((n == 64) && ($urandom_range(0, 1) == 1)) ? 8'd0 : 8'(n);
        else ll = 8'($urandom_range(0, 255));
        for (int i = 0; i < n; i++) begin
          int guard;
          guard = 0;
          while (bus.full_o) begin
            bus.blk_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
            guard++;
            if (guard > 200) begin
              timeout("full_wait");
              break;
            end
          end
          if ($urandom_range(0, 3) == 0) begin
            bus.blk_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
          end
          bus.blk_ready_i = ($urandom_range(0, 2) != 0);
          send(8'($urandom_range(0, 255)), i, (b == 0), lst, ll);
        end
      end
    end

    bus.blk_ready_i = 1'b1;
    begin
      int guard;
      guard = 0;
      while (bus.blk_v_o) begin
        cycle();
        guard++;
        if (guard > 10) begin
          timeout("final_drain");
          break;
        end
      end
    end
    cycle();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
